// File: rtl/ase_pkg.sv
// Shared constants for the ASE write-response channel models: LFSR seed,
// feedback polynomial and the default latency window.
package ase_pkg;

   localparam logic [7:0] WRF_LFSR_SEED   = 8'hA5;
   // x^8 + x^6 + x^5 + x^4 + 1 expressed as a mask over state bits [7:0]
   localparam logic [7:0] WRF_LFSR_TAPS   = 8'b1011_1000;
   localparam int         WRF_MIN_LATENCY = 2;
   localparam int         WRF_MAX_LATENCY = 9;

   function automatic logic lfsr_feedback(input logic [7:0] state);
      return ^(state & WRF_LFSR_TAPS);
   endfunction

endpackage

// File: rtl/wrf_latency_lfsr.sv
// 8-bit Fibonacci LFSR that supplies pseudo-random hold latencies; it only
// steps when a transaction is accepted so the latency sequence is repeatable.
module wrf_latency_lfsr
   import ase_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   output logic [7:0] value
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance) begin
         lfsr_d = {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= WRF_LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/out_of_order_wrf_channel.sv
// Write channel model: buffers header+data transactions, holds each for a
// pseudo-random latency and releases matured entries lowest-slot first.
module out_of_order_wrf_channel
   import ase_pkg::*;
#(
   parameter int NUM_TRANSACTIONS = 4,
   parameter int HDR_WIDTH        = 80,
   parameter int DATA_WIDTH       = 64,
   parameter int MIN_LATENCY      = WRF_MIN_LATENCY,
   parameter int MAX_LATENCY      = WRF_MAX_LATENCY
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [HDR_WIDTH-1:0]                meta_in,
   input  logic [DATA_WIDTH-1:0]               data_in,
   input  logic                                valid_in,
   output logic [HDR_WIDTH-1:0]                meta_out,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                valid_out,
   input  logic                                read_en,
   output logic                                empty,
   output logic                                full,
   output logic                                overflow,
   output logic                                underflow,
   output logic [$clog2(NUM_TRANSACTIONS):0]   count
);

   localparam int IDX_W     = $clog2(NUM_TRANSACTIONS);
   localparam int CNT_W     = IDX_W + 1;
   localparam int LAT_W     = $clog2(MAX_LATENCY + 1);
   localparam int LAT_RANGE = MAX_LATENCY - MIN_LATENCY + 1;

   logic [NUM_TRANSACTIONS-1:0] occ_q, occ_d;
   logic [HDR_WIDTH-1:0]        meta_q [NUM_TRANSACTIONS];
   logic [HDR_WIDTH-1:0]        meta_d [NUM_TRANSACTIONS];
   logic [DATA_WIDTH-1:0]       data_q [NUM_TRANSACTIONS];
   logic [DATA_WIDTH-1:0]       data_d [NUM_TRANSACTIONS];
   logic [LAT_W-1:0]            cd_q   [NUM_TRANSACTIONS];
   logic [LAT_W-1:0]            cd_d   [NUM_TRANSACTIONS];
   logic [CNT_W-1:0]            count_q, count_d;
   logic [HDR_WIDTH-1:0]        meta_out_q, meta_out_d;
   logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;
   logic                        valid_out_q, valid_out_d;
   logic                        overflow_q, overflow_d;
   logic                        underflow_q, underflow_d;

   logic [7:0]                  lfsr_value;
   logic [LAT_W-1:0]            load_latency;
   logic                        write_accept;
   logic                        read_hit;
   logic                        sel_found;
   logic [IDX_W-1:0]            alloc_idx;
   logic [IDX_W-1:0]            sel_idx;

   wrf_latency_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (write_accept),
      .value   (lfsr_value)
   );

   assign full  = (count_q == CNT_W'(NUM_TRANSACTIONS));
   assign empty = (count_q == '0);

   assign load_latency = LAT_W'(MIN_LATENCY) + LAT_W'(32'(lfsr_value) % 32'(LAT_RANGE));

   // Allocation and selection both scan the pre-edge state, so a slot freed
   // this cycle is only reusable from the next one.
   always_comb begin
      alloc_idx = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = NUM_TRANSACTIONS - 1; i >= 0; i--) begin
         if (!occ_q[i]) begin
            alloc_idx = IDX_W'(i);
         end
         if (occ_q[i] && (cd_q[i] == '0)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   assign write_accept = valid_in && !full;
   assign read_hit     = read_en && sel_found;

   always_comb begin
      occ_d       = occ_q;
      meta_d      = meta_q;
      data_d      = data_q;
      cd_d        = cd_q;
      meta_out_d  = meta_out_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      overflow_d  = valid_in && full;
      underflow_d = read_en && empty;
      count_d     = count_q + CNT_W'(write_accept) - CNT_W'(read_hit);

      for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
         if (occ_q[i] && (cd_q[i] != '0)) begin
            cd_d[i] = cd_q[i] - LAT_W'(1);
         end
      end

      if (read_hit) begin
         occ_d[sel_idx] = 1'b0;
         meta_out_d     = meta_q[sel_idx];
         data_out_d     = data_q[sel_idx];
         valid_out_d    = 1'b1;
      end

      if (write_accept) begin
         occ_d[alloc_idx]  = 1'b1;
         meta_d[alloc_idx] = meta_in;
         data_d[alloc_idx] = data_in;
         cd_d[alloc_idx]   = load_latency;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q       <= '0;
         count_q     <= '0;
         meta_out_q  <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < NUM_TRANSACTIONS; i++) begin
            meta_q[i] <= '0;
            data_q[i] <= '0;
            cd_q[i]   <= '0;
         end
      end else begin
         occ_q       <= occ_d;
         count_q     <= count_d;
         meta_out_q  <= meta_out_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         meta_q      <= meta_d;
         data_q      <= data_d;
         cd_q        <= cd_d;
      end
   end

   assign meta_out  = meta_out_q;
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign count     = count_q;

endmodule

// File: tb/tb_out_of_order_wrf_channel.sv
// Self-checking bench: lockstep timestamp-based reference model, a vector
// table for fill/overflow/underflow, and directed plus random sequences.
module tb_out_of_order_wrf_channel;

   localparam int N    = 4;
   localparam int MINL = 2;
   localparam int MAXL = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [79:0] meta_in = '0;
   logic [63:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        read_en = 1'b0;
   logic [79:0] meta_out;
   logic [63:0] data_out;
   logic        valid_out;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        underflow;
   logic [2:0]  count;

   int check_count = 0;
   int pass_count  = 0;

   out_of_order_wrf_channel dut (
      .clk       (clk),
      .rst       (rst),
      .meta_in   (meta_in),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .meta_out  (meta_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .read_en   (read_en),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Reference model: each entry remembers the clock edge from which it may be popped
   bit          m_occ    [N];
   logic [79:0] m_meta   [N];
   logic [63:0] m_data   [N];
   int          m_mature [N];
   int          m_edge;
   int          m_count;
   logic [7:0]  m_lfsr;
   logic        m_valid, m_ovf, m_udf;
   logic [79:0] m_meta_out;
   logic [63:0] m_data_out;

   function automatic logic [7:0] lfsrNext(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task modelReset();
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
      m_edge = 0; m_count = 0; m_lfsr = 8'hA5;
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      m_meta_out = '0; m_data_out = '0;
   endtask

   task modelStep(input bit v, input bit r, input logic [79:0] m, input logic [63:0] d);
      int  alloc, sel;
      bit  was_full, was_empty;
      m_edge++;
      was_full  = (m_count == N);
      was_empty = (m_count == 0);
      m_ovf = v && was_full;
      m_udf = r && was_empty;
      alloc = -1; sel = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (!m_occ[i]) alloc = i;
         if (m_occ[i] && m_edge >= m_mature[i]) sel = i;
      end
      m_valid = 1'b0;
      if (r && sel >= 0) begin
         m_occ[sel] = 1'b0;
         m_valid = 1'b1;
         m_meta_out = m_meta[sel];
         m_data_out = m_data[sel];
      end
      if (v && !was_full && alloc >= 0) begin
         m_occ[alloc]    = 1'b1;
         m_meta[alloc]   = m;
         m_data[alloc]   = d;
         m_mature[alloc] = m_edge + MINL + int'(m_lfsr) % (MAXL - MINL + 1) + 1;
         m_lfsr = lfsrNext(m_lfsr);
      end
      m_count = 0;
      for (int i = 0; i < N; i++) if (m_occ[i]) m_count++;
   endtask

   task checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
   endtask

   task compareModel();
      checkOutput("valid_out", 128'(valid_out), 128'(m_valid));
      checkOutput("meta_out",  128'(meta_out),  128'(m_meta_out));
      checkOutput("data_out",  128'(data_out),  128'(m_data_out));
      checkOutput("overflow",  128'(overflow),  128'(m_ovf));
      checkOutput("underflow", 128'(underflow), 128'(m_udf));
      checkOutput("count",     128'(count),     128'(m_count));
      checkOutput("empty",     128'(empty),     128'(m_count == 0));
      checkOutput("full",      128'(full),      128'(m_count == N));
   endtask

   // One clock of stimulus: drive, predict, clock, compare against the model
   task applyStimulus(input bit v, input bit r, input logic [79:0] m, input logic [63:0] d);
      valid_in = v; read_en = r; meta_in = m; data_in = d;
      modelStep(v, r, m, d);
      @(posedge clk);
      #1;
      compareModel();
   endtask

   typedef struct {
      bit          v;
      bit          r;
      logic [79:0] meta;
      logic [63:0] data;
      int          exp_count;
      bit          exp_full;
      bit          exp_empty;
      bit          exp_ovf;
      bit          exp_udf;
      bit          exp_valid;
   } vec_t;

   vec_t        vecs [9];
   int          seen [257];
   int          pulses, pulse_edge, wr_edge, released, e_seen, steps, written, max_idx, bad, idx;
   bit          ooo;
   logic [79:0] got_meta;
   logic [63:0] got_data;
   logic [95:0] r96;
   logic [63:0] r64;
   localparam logic [79:0] META_E = 80'hEEEE_0000_0000_0000_00EE;

   initial begin
      modelReset();
      // Power-on reset held for 40 clocks
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("reset_empty",     128'(empty),     128'(1));
      checkOutput("reset_full",      128'(full),      128'(0));
      checkOutput("reset_count",     128'(count),     128'(0));
      checkOutput("reset_valid_out", 128'(valid_out), 128'(0));
      checkOutput("reset_overflow",  128'(overflow),  128'(0));
      checkOutput("reset_underflow", 128'(underflow), 128'(0));
      rst = 1'b1;

      // Single transaction round trip
      applyStimulus(1'b1, 1'b0, 80'h01_00000000_00000000, 64'hCAFEBABE_BEBAFECA);
      wr_edge = m_edge; pulses = 0; pulse_edge = 0; got_meta = '0; got_data = '0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1'b0, m_count != 0, '0, '0);
         if (valid_out) begin
            pulses++;
            if (pulses == 1) begin
               pulse_edge = m_edge; got_meta = meta_out; got_data = data_out;
            end
         end
      end
      checkOutput("single_pulses",     128'(pulses),   128'(1));
      checkOutput("single_meta",       128'(got_meta), 128'(80'h01_00000000_00000000));
      checkOutput("single_data",       128'(got_data), 128'(64'hCAFEBABE_BEBAFECA));
      checkOutput("single_latency_ok", 128'(pulse_edge - wr_edge >= MINL + 1), 128'(1));
      checkOutput("single_empty_after", 128'(empty), 128'(1));

      // Underflow, fill to full, overflow while full
      vecs[0] = '{1'b0, 1'b1, 80'h0, 64'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 80'h0, 64'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 80'hAAAA_0000_0000_0000_0001, 64'h1111, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 80'hAAAA_0000_0000_0000_0002, 64'h2222, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 80'hAAAA_0000_0000_0000_0003, 64'h3333, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 80'hAAAA_0000_0000_0000_0004, 64'h4444, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, META_E, 64'hEEEE, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, META_E, 64'hEEEE, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 80'h0, 64'h0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 9; k++) begin
         applyStimulus(vecs[k].v, vecs[k].r, vecs[k].meta, vecs[k].data);
         checkOutput($sformatf("vec%0d_count", k),     128'(count),     128'(vecs[k].exp_count));
         checkOutput($sformatf("vec%0d_full", k),      128'(full),      128'(vecs[k].exp_full));
         checkOutput($sformatf("vec%0d_empty", k),     128'(empty),     128'(vecs[k].exp_empty));
         checkOutput($sformatf("vec%0d_overflow", k),  128'(overflow),  128'(vecs[k].exp_ovf));
         checkOutput($sformatf("vec%0d_underflow", k), 128'(underflow), 128'(vecs[k].exp_udf));
         checkOutput($sformatf("vec%0d_valid_out", k), 128'(valid_out), 128'(vecs[k].exp_valid));
      end
      released = 0; e_seen = 0;
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1'b0, 1'b1, '0, '0);
         if (valid_out) begin
            released++;
            if (meta_out == META_E) e_seen++;
         end
      end
      checkOutput("fill_drained", 128'(released), 128'(4));
      checkOutput("fill_dropped_never_out", 128'(e_seen), 128'(0));

      // Asynchronous reset with three entries still buffered
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 80'hBB00 + 80'(k), 64'(k));
      for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, '0, '0);
      checkOutput("pre_async_count", 128'(count), 128'(3));
      #2 rst = 1'b0;
      #1;
      checkOutput("async_count",     128'(count),     128'(0));
      checkOutput("async_valid_out", 128'(valid_out), 128'(0));
      checkOutput("async_empty",     128'(empty),     128'(1));
      modelReset();
      @(posedge clk);
      #1 rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("post_reset_meta_out", 128'(meta_out), 128'(0));

      // 256-write stream with ~full / ~empty gating
      for (int k = 0; k <= 256; k++) seen[k] = 0;
      released = 0; written = 0; steps = 0; max_idx = 0; ooo = 1'b0;
      while (released < 256 && steps < 4000) begin
         steps++;
         r64 = {$urandom, $urandom};
         if (written < 256 && m_count != N) begin
            written++;
            applyStimulus(1'b1, m_count != 0, {16'(written), 64'h0}, r64);
         end else begin
            applyStimulus(1'b0, m_count != 0, '0, '0);
         end
         if (valid_out) begin
            released++;
            idx = int'(meta_out[79:64]);
            if (idx >= 1 && idx <= 256) seen[idx]++;
            if (idx < max_idx) ooo = 1'b1;
            else max_idx = idx;
         end
      end
      bad = 0;
      for (int k = 1; k <= 256; k++) if (seen[k] != 1) bad++;
      checkOutput("stream_count",        128'(released), 128'(256));
      checkOutput("stream_unique",       128'(bad),      128'(0));
      checkOutput("stream_out_of_order", 128'(ooo),      128'(1));

      // Random traffic against the model
      for (int k = 0; k < 800; k++) begin
         r96 = {$urandom, $urandom, $urandom};
         r64 = {$urandom, $urandom};
         applyStimulus(($urandom % 100) < 60, ($urandom % 100) < 50, r96[79:0], r64);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
